// File: rtl/dcache_assoc_if.sv
// Request/response and memory-side bus of dcache_assoc.
// flushIn/flushDone exist only when DCACHE_FLUSH_EN is defined.
interface dcache_assoc_if #(
  parameter int BLOCK_WIDTH = 4
);
  logic                            reqValid;
  logic                            reqReady;
  logic                            reqWrite;
  logic [1:0]                      reqSize;
  logic [31:0]                     reqAddr;
  logic [31:0]                     reqData;
  logic                            respValid;
  logic [31:0]                     respData;
  logic                            memReqValid;
  logic                            memReqReady;
  logic                            memReqWrite;
  logic [31:BLOCK_WIDTH]           memReqAddr;
  logic [(2**BLOCK_WIDTH)*8-1:0]   memWriteData;
  logic                            memRespValid;
  logic [(2**BLOCK_WIDTH)*8-1:0]   memRespData;
`ifdef DCACHE_FLUSH_EN
  logic                            flushIn;
  logic                            flushDone;
`endif

  modport slave (
    input  reqValid, reqWrite, reqSize, reqAddr, reqData,
    input  memReqReady, memRespValid, memRespData,
    output reqReady, respValid, respData,
    output memReqValid, memReqWrite, memReqAddr, memWriteData
`ifdef DCACHE_FLUSH_EN
    , input flushIn, output flushDone
`endif
  );

  modport master (
    output reqValid, reqWrite, reqSize, reqAddr, reqData,
    output memReqReady, memRespValid, memRespData,
    input  reqReady, respValid, respData,
    input  memReqValid, memReqWrite, memReqAddr, memWriteData
`ifdef DCACHE_FLUSH_EN
    , output flushIn, input flushDone
`endif
  );
endinterface

// File: rtl/dcache_assoc.sv
// dcache_assoc: write-back, write-allocate data cache with 1- or 2-way LRU sets.
// Defining DCACHE_FLUSH_EN adds a whole-cache writeback/invalidate (FLUSH state).
module dcache_assoc #(
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 8,
  parameter int WAYS        = 2
) (
  input  logic          clkIn,
  input  logic          resetIn,
  input  logic          clearIn,
  dcache_assoc_if.slave bus
);
  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;
  localparam int LW         = BLOCK_SIZE * 8;
  localparam int SETS       = 2 ** SET_WIDTH;
  localparam int TW         = 32 - SET_WIDTH - BLOCK_WIDTH;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3
`ifdef DCACHE_FLUSH_EN
    , FLUSH   = 3'd4
`endif
  } state_t;

  state_t                r_state, w_next;
  logic                  r_write, r_abort, r_wait, r_way, r_respValid;
  logic [1:0]            r_size;
  logic [31:0]           r_addr, r_data, r_respData;
  logic [31:BLOCK_WIDTH] r_memAddr;
  logic [LW-1:0]         r_memData;
  logic [SETS-1:0]       r_valid [WAYS];
  logic [SETS-1:0]       r_dirty [WAYS];
  logic [SETS-1:0]       r_lru;
  logic [TW-1:0]         r_tag  [WAYS][SETS];
  logic [LW-1:0]         r_line [WAYS][SETS];

  logic [SET_WIDTH-1:0]  w_set;
  logic [TW-1:0]         w_tag;
  logic [BLOCK_WIDTH+2:0] w_shift;
  logic [WAYS-1:0]       w_match;
  logic                  w_hit, w_hitWay, w_vicWay, w_vicDirty;
  logic                  w_accept, w_loadAbort, w_fill, w_store;
  logic                  w_memReqValid, w_memReqWrite;
  logic [31:0]           w_mask32, w_loadData;
  logic [LW-1:0]         w_hitLine, w_byteMask, w_merged;

  assign w_set       = r_addr[SET_WIDTH+BLOCK_WIDTH-1:BLOCK_WIDTH];
  assign w_tag       = r_addr[31:SET_WIDTH+BLOCK_WIDTH];
  assign w_shift     = {r_addr[BLOCK_WIDTH-1:0], 3'b000};
  assign w_loadAbort = clearIn && !r_write;
  assign w_fill      = (r_state == REFILL) && r_wait && bus.memRespValid;
  assign w_store     = (r_state == LOOKUP) && w_hit && r_write;

`ifdef DCACHE_FLUSH_EN
  logic [SET_WIDTH:0]   r_fidx;
  logic                 r_fwb, r_flushDone;
  logic                 w_fWay, w_fDirty, w_fStep, w_fLast;
  logic [SET_WIDTH-1:0] w_fSet;
  // Walk order is set-major, way 0 before way 1; a 1-way cache revisits way 0 harmlessly.
  assign w_fWay   = r_fidx[0] & 1'(WAYS == 2);
  assign w_fSet   = r_fidx[SET_WIDTH:1];
  assign w_fDirty = r_valid[w_fWay][w_fSet] && r_dirty[w_fWay][w_fSet];
  assign w_fStep  = (r_state == FLUSH) && (r_fwb ? bus.memReqReady : !w_fDirty);
  assign w_fLast  = &r_fidx;
  assign w_accept = (r_state == IDLE) && !clearIn && !bus.flushIn && bus.reqValid && (bus.reqSize != 2'b00);
  assign bus.flushDone = r_flushDone;
`else
  assign w_accept = (r_state == IDLE) && !clearIn && bus.reqValid && (bus.reqSize != 2'b00);
`endif

  // Tag compare, victim selection and byte-lane alignment for the pending request.
  always_comb begin
    w_match = {WAYS{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      w_match[w] = r_valid[w][w_set] && (r_tag[w][w_set] == w_tag);
    end
    w_hit    = |w_match;
    w_hitWay = (WAYS == 2) ? w_match[WAYS-1] : 1'b0;
    if (WAYS == 1)                    w_vicWay = 1'b0;
    else if (!r_valid[0][w_set])      w_vicWay = 1'b0;
    else if (!r_valid[WAYS-1][w_set]) w_vicWay = 1'b1;
    else                              w_vicWay = r_lru[w_set];
    w_vicDirty = r_valid[w_vicWay][w_set] && r_dirty[w_vicWay][w_set];
    case (r_size)
      2'b01:   w_mask32 = 32'h0000_00FF;
      2'b10:   w_mask32 = 32'h0000_FFFF;
      default: w_mask32 = 32'hFFFF_FFFF;
    endcase
    w_hitLine  = r_line[w_hitWay][w_set];
    w_loadData = w_mask32 & 32'(w_hitLine >> w_shift);
    w_byteMask = LW'(w_mask32) << w_shift;
    w_merged   = (w_hitLine & ~w_byteMask) | ((LW'(r_data & w_mask32) << w_shift) & w_byteMask);
  end

  // State register.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state and memory handshake decode.
  always_comb begin
    w_next        = r_state;
    w_memReqValid = 1'b0;
    w_memReqWrite = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef DCACHE_FLUSH_EN
        if (bus.flushIn)    w_next = FLUSH;
        else if (w_accept)  w_next = LOOKUP;
        else                w_next = IDLE;
`else
        if (w_accept) w_next = LOOKUP;
        else          w_next = IDLE;
`endif
      end
      LOOKUP: begin
        if (w_loadAbort || w_hit) w_next = IDLE;
        else if (w_vicDirty)      w_next = WRITEBACK;
        else                      w_next = REFILL;
      end
      WRITEBACK: begin
        w_memReqValid = 1'b1;
        w_memReqWrite = 1'b1;
        if (bus.memReqReady) w_next = REFILL;
        else                 w_next = WRITEBACK;
      end
      REFILL: begin
        w_memReqValid = !r_wait;
        if (w_fill) w_next = (r_abort || w_loadAbort) ? IDLE : LOOKUP;
        else        w_next = REFILL;
      end
`ifdef DCACHE_FLUSH_EN
      FLUSH: begin
        w_memReqValid = r_fwb;
        w_memReqWrite = r_fwb;
        if (w_fStep && w_fLast) w_next = IDLE;
        else                    w_next = FLUSH;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  assign bus.reqReady     = (r_state == IDLE) && !clearIn;
  assign bus.respValid    = r_respValid;
  assign bus.respData     = r_respData;
  assign bus.memReqValid  = w_memReqValid;
  assign bus.memReqWrite  = w_memReqWrite;
  assign bus.memReqAddr   = r_memAddr;
  assign bus.memWriteData = r_memData;

  // Request capture, valid/dirty/LRU bookkeeping and memory-side registers.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= {SETS{1'b0}};
        r_dirty[w] <= {SETS{1'b0}};
      end
      r_lru       <= {SETS{1'b0}};
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= 32'h0;
      r_data      <= 32'h0;
      r_abort     <= 1'b0;
      r_wait      <= 1'b0;
      r_way       <= 1'b0;
      r_memAddr   <= {(32-BLOCK_WIDTH){1'b0}};
      r_memData   <= {LW{1'b0}};
      r_respValid <= 1'b0;
      r_respData  <= 32'h0;
`ifdef DCACHE_FLUSH_EN
      r_fidx      <= {(SET_WIDTH+1){1'b0}};
      r_fwb       <= 1'b0;
      r_flushDone <= 1'b0;
`endif
    end else begin
      r_respValid <= 1'b0;
`ifdef DCACHE_FLUSH_EN
      r_flushDone <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
`ifdef DCACHE_FLUSH_EN
          r_fidx <= {(SET_WIDTH+1){1'b0}};
          r_fwb  <= 1'b0;
`endif
          if (w_accept) begin
            r_write <= bus.reqWrite;
            r_size  <= bus.reqSize;
            r_addr  <= {bus.reqAddr[31:2],
                        bus.reqAddr[1] & (bus.reqSize != 2'b11),
                        bus.reqAddr[0] & (bus.reqSize == 2'b01)};
            r_data  <= bus.reqData;
            r_abort <= 1'b0;
          end
        end
        LOOKUP: begin
          r_wait <= 1'b0;
          if (!w_loadAbort && w_hit) begin
            r_respValid   <= 1'b1;
            r_respData    <= r_write ? 32'h0 : w_loadData;
            r_lru[w_set]  <= ~w_hitWay;
            if (r_write) r_dirty[w_hitWay][w_set] <= 1'b1;
          end else if (!w_loadAbort) begin
            r_way <= w_vicWay;
            if (w_vicDirty) begin
              r_memAddr <= {r_tag[w_vicWay][w_set], w_set};
              r_memData <= r_line[w_vicWay][w_set];
            end else begin
              r_memAddr <= r_addr[31:BLOCK_WIDTH];
            end
          end
        end
        WRITEBACK: begin
          if (w_loadAbort) r_abort <= 1'b1;
          if (bus.memReqReady) begin
            r_dirty[r_way][w_set] <= 1'b0;
            r_memAddr             <= r_addr[31:BLOCK_WIDTH];
          end
        end
        REFILL: begin
          if (w_loadAbort) r_abort <= 1'b1;
          if (!r_wait && bus.memReqReady) r_wait <= 1'b1;
          if (w_fill) begin
            r_valid[r_way][w_set] <= 1'b1;
            r_dirty[r_way][w_set] <= 1'b0;
            r_lru[w_set]          <= ~r_way;
            r_wait                <= 1'b0;
          end
        end
`ifdef DCACHE_FLUSH_EN
        FLUSH: begin
          if (!r_fwb && w_fDirty) begin
            r_memAddr <= {r_tag[w_fWay][w_fSet], w_fSet};
            r_memData <= r_line[w_fWay][w_fSet];
            r_fwb     <= 1'b1;
          end
          if (w_fStep) begin
            r_valid[w_fWay][w_fSet] <= 1'b0;
            r_dirty[w_fWay][w_fSet] <= 1'b0;
            r_fwb                   <= 1'b0;
            r_fidx                  <= r_fidx + 1'b1;
            if (w_fLast) r_flushDone <= 1'b1;
          end
        end
`endif
        default: r_abort <= 1'b0;
      endcase
    end
  end

  // Line and tag storage, written only by store hits and refill installs.
  always_ff @(posedge clkIn) begin
    if (w_store) begin
      r_line[w_hitWay][w_set] <= w_merged;
    end else if (w_fill) begin
      r_line[r_way][w_set] <= bus.memRespData;
      r_tag[r_way][w_set]  <= w_tag;
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc with a small line-memory model; the flush
// scenario is included when DCACHE_FLUSH_EN is defined.
module tb_dcache_assoc;
  localparam int BW = 4;
  localparam int SW = 8;
  localparam int LW = 128;

  logic clkIn = 1'b0;
  logic resetIn = 1'b0;
  logic clearIn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dcache_assoc_if #(.BLOCK_WIDTH(BW)) bus ();
  dcache_assoc #(.BLOCK_WIDTH(BW), .SET_WIDTH(SW), .WAYS(2)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn), .bus(bus));

  always #5 clkIn = ~clkIn;

  logic [LW-1:0] mem [logic [27:0]];
  logic          log_w [$];
  logic [27:0]   log_a [$];
  logic          pend = 1'b0;
  logic [27:0]   pend_a = 28'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_rd(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return {4{4'h0, a}};
  endfunction

  // One cycle of the memory model: grant any request, answer a refill one cycle later.
  task automatic mem_cycle();
    bus.memReqReady  = 1'b0;
    bus.memRespValid = 1'b0;
    if (pend) begin
      bus.memRespValid = 1'b1;
      bus.memRespData  = mem_rd(pend_a);
      pend = 1'b0;
    end else if (bus.memReqValid) begin
      bus.memReqReady = 1'b1;
      log_w.push_back(bus.memReqWrite);
      log_a.push_back(bus.memReqAddr);
      if (bus.memReqWrite) mem[bus.memReqAddr] = bus.memWriteData;
      else begin
        pend   = 1'b1;
        pend_a = bus.memReqAddr;
      end
    end
  endtask

  // Issue one request (called just after a negedge with the cache idle) and run it to completion.
  task automatic run(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input logic clr_refill, output logic got, output logic [31:0] rd,
                     output int lat, output logic tmo);
    got = 1'b0; rd = 32'h0; lat = 0; tmo = 1'b1;
    bus.reqValid = 1'b1; bus.reqWrite = w; bus.reqSize = sz; bus.reqAddr = a; bus.reqData = d;
    @(posedge clkIn);
    #1 bus.reqValid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clkIn);
      bus.memReqReady  = 1'b0;
      bus.memRespValid = 1'b0;
      if (bus.respValid) begin
        got = 1'b1; rd = bus.respData; lat = n; tmo = 1'b0;
        break;
      end
      if (bus.reqReady) begin
        tmo = 1'b0;
        break;
      end
      clearIn = 1'b0;
      if (clr_refill && bus.memReqValid && !bus.memReqWrite) clearIn = 1'b1;
      mem_cycle();
    end
    clearIn = 1'b0;
  endtask

  initial begin
    logic        got, tmo, found;
    logic [31:0] rd;
    int          lat, nlog;
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'b00;
    bus.reqAddr = 32'h0; bus.reqData = 32'h0;
    bus.memReqReady = 1'b0; bus.memRespValid = 1'b0; bus.memRespData = {LW{1'b0}};
`ifdef DCACHE_FLUSH_EN
    bus.flushIn = 1'b0;
`endif
    mem[28'h100] = 128'h33333333_22222222_DEADBEEF_11111111;

    repeat (2) @(negedge clkIn);
    check("rst_respValid", bus.respValid, 1'b0);
    check("rst_respData", bus.respData, 32'h0);
    check("rst_memReqValid", bus.memReqValid, 1'b0);
    check("rst_memReqWrite", bus.memReqWrite, 1'b0);
    resetIn = 1'b1;
    @(negedge clkIn);
    check("rst_reqReady", bus.reqReady, 1'b1);

    bus.reqValid = 1'b1; bus.reqSize = 2'b00; bus.reqAddr = 32'h1004;
    @(negedge clkIn);
    check("size00_ignored", bus.reqReady, 1'b1);
    check("size00_nomem", bus.memReqValid, 1'b0);
    bus.reqValid = 1'b0;
    @(negedge clkIn);

    run(1'b0, 2'b11, 32'h1004, 32'h0, 1'b0, got, rd, lat, tmo);
    check("cold_done", tmo, 1'b0);
    check("cold_resp", got, 1'b1);
    check("cold_data", rd, 32'hDEADBEEF);
    check("cold_nmem", log_a.size(), 1);
    check("cold_memw", log_w[0], 1'b0);
    check("cold_mema", log_a[0], 28'h100);

    run(1'b0, 2'b11, 32'h1004, 32'h0, 1'b0, got, rd, lat, tmo);
    check("hit_data", rd, 32'hDEADBEEF);
    check("hit_lat", lat, 2);
    check("hit_nmem", log_a.size(), 1);

    run(1'b1, 2'b01, 32'h1005, 32'h000000AB, 1'b0, got, rd, lat, tmo);
    check("stb_resp", got, 1'b1);
    check("stb_data0", rd, 32'h0);
    check("stb_lat", lat, 2);
    run(1'b0, 2'b11, 32'h1004, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ldw_merged", rd, 32'hDEADABEF);
    run(1'b0, 2'b10, 32'h1007, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ldh_aligned", rd, 32'h0000DEAD);
    run(1'b0, 2'b01, 32'h1008, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ldb_word2", rd, 32'h00000022);

    run(1'b0, 2'b11, 32'h1000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ld1000_data", rd, 32'h11111111);
    run(1'b0, 2'b11, 32'h2000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ld2000_data", rd, 32'h00000200);
    run(1'b1, 2'b11, 32'h2000, 32'hCAFEF00D, 1'b0, got, rd, lat, tmo);
    run(1'b0, 2'b11, 32'h1000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("lru_touch_hit", lat, 2);
    nlog = log_a.size();
    run(1'b0, 2'b11, 32'h3000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("ev_data", rd, 32'h00000300);
    check("ev_nmem", log_a.size(), nlog + 2);
    check("ev_wb_w", log_w[nlog], 1'b1);
    check("ev_wb_a", log_a[nlog], 28'h200);
    check("ev_rf_w", log_w[nlog+1], 1'b0);
    check("ev_rf_a", log_a[nlog+1], 28'h300);
    check("ev_wb_data", mem[28'h200][31:0], 32'hCAFEF00D);
    run(1'b0, 2'b11, 32'h1004, 32'h0, 1'b0, got, rd, lat, tmo);
    check("keep1000_data", rd, 32'hDEADABEF);
    check("keep1000_nmem", log_a.size(), nlog + 2);

    nlog = log_a.size();
    run(1'b0, 2'b11, 32'h4000, 32'h0, 1'b1, got, rd, lat, tmo);
    check("clr_done", tmo, 1'b0);
    check("clr_noresp", got, 1'b0);
    check("clr_nmem", log_a.size(), nlog + 1);
    run(1'b0, 2'b11, 32'h4000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("clr_then_hit", rd, 32'h00000400);
    check("clr_hit_lat", lat, 2);
    check("clr_hit_nmem", log_a.size(), nlog + 1);

    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = 2'b11; bus.reqAddr = 32'h5000;
    @(posedge clkIn);
    #1 bus.reqValid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clkIn);
      found = bus.memReqValid && bus.memReqWrite;
    end
    check("wb_seen", found, 1'b1);
    check("wb_addr", bus.memReqAddr, 28'h100);
    #2 resetIn = 1'b0;
    #1 check("rst_async_memReqValid", bus.memReqValid, 1'b0);
    @(negedge clkIn);
    resetIn = 1'b1;
    @(negedge clkIn);
    check("rel_reqReady", bus.reqReady, 1'b1);
    nlog = log_a.size();
    run(1'b0, 2'b11, 32'h1004, 32'h0, 1'b0, got, rd, lat, tmo);
    check("rel_miss_nmem", log_a.size(), nlog + 1);
    check("rel_miss_a", log_a[nlog], 28'h100);
    check("rel_miss_data", rd, 32'hDEADBEEF);

`ifdef DCACHE_FLUSH_EN
    run(1'b1, 2'b11, 32'h1000, 32'h1111AAAA, 1'b0, got, rd, lat, tmo);
    run(1'b1, 2'b11, 32'h2000, 32'h2222BBBB, 1'b0, got, rd, lat, tmo);
    nlog = log_a.size();
    bus.flushIn = 1'b1;
    @(posedge clkIn);
    #1 bus.flushIn = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clkIn);
      bus.memReqReady = 1'b0; bus.memRespValid = 1'b0;
      found = bus.flushDone;
      if (!found) mem_cycle();
    end
    check("fl_done", found, 1'b1);
    check("fl_nmem", log_a.size(), nlog + 2);
    check("fl_wb0_a", log_a[nlog], 28'h100);
    check("fl_wb1_a", log_a[nlog+1], 28'h200);
    check("fl_wb0_data", mem[28'h100][31:0], 32'h1111AAAA);
    @(negedge clkIn);
    run(1'b0, 2'b11, 32'h1000, 32'h0, 1'b0, got, rd, lat, tmo);
    check("fl_miss_nmem", log_a.size(), nlog + 3);
    check("fl_miss_data", rd, 32'h1111AAAA);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
